// File: rtl/window_hamming_cost_pkg.sv
// Shared SGM datapath types: census codes, matching cost and raster position tags.
package window_hamming_cost_pkg;

  localparam int PIXEL_DEPTH      = 32;
  localparam int SGM_FRAME_WIDTH  = 640;
  localparam int SGM_FRAME_HEIGHT = 480;
  localparam int COL_W            = 10;
  localparam int ROW_W            = 9;
  localparam int POP_W            = $clog2(PIXEL_DEPTH + 1);

  typedef logic [PIXEL_DEPTH-1:0] census_t;
  typedef logic [COL_W-1:0]       col_t;
  typedef logic [ROW_W-1:0]       row_t;
  typedef logic [POP_W-1:0]       pop_t;

  function automatic int cost_width(input int block_width, input int block_height);
    return $clog2(block_width * block_height * PIXEL_DEPTH + 1);
  endfunction

  localparam int COST_W_DEF = cost_width(1, 8);
  typedef logic [COST_W_DEF-1:0] cost_t;

  typedef struct packed {
    row_t row;
    col_t col;
  } tag_t;

endpackage

// File: rtl/window_hamming_cost_popcount32.sv
// Registered 32-bit popcount; shared with the aggregation stage.
module popcount32
  import window_hamming_cost_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  census_t din,
  output pop_t    cnt
);

  pop_t sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < PIXEL_DEPTH; i++) sum = sum + pop_t'(din[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= sum;
  end

endmodule

// File: rtl/window_hamming_cost.sv
// Hamming matching cost over a left/right census window pair, 3-stage pipeline
// with raster position tagging and window-fill qualification.
module window_hamming_cost
  import window_hamming_cost_pkg::*;
#(
  parameter  int BLOCK_WIDTH  = 1,
  parameter  int BLOCK_HEIGHT = 8,
  parameter  int FRAME_WIDTH  = SGM_FRAME_WIDTH,
  parameter  int FRAME_HEIGHT = SGM_FRAME_HEIGHT,
  localparam int NUM_ELEM     = BLOCK_WIDTH * BLOCK_HEIGHT,
  localparam int WIN_W        = NUM_ELEM * PIXEL_DEPTH,
  localparam int COST_W       = cost_width(BLOCK_WIDTH, BLOCK_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              win_valid,
  input  logic              sof,
  input  logic [WIN_W-1:0]  win_l,
  input  logic [WIN_W-1:0]  win_r,
  output logic [COST_W-1:0] cost,
  output logic              cost_valid,
  output col_t              cost_col,
  output row_t              cost_row,
  output logic              overrun
);

  localparam int STAGES = 2;

  // Raster position of the pixel currently presented
  col_t col_cnt, cur_col, nxt_col;
  row_t row_cnt, cur_row, nxt_row;
  logic last_px, done;

  always_comb begin
    cur_col = sof ? '0 : col_cnt;
    cur_row = sof ? '0 : row_cnt;
    last_px = (cur_col == col_t'(FRAME_WIDTH - 1)) && (cur_row == row_t'(FRAME_HEIGHT - 1));
    nxt_col = cur_col;
    nxt_row = cur_row;
    if (!last_px) begin
      if (cur_col == col_t'(FRAME_WIDTH - 1)) begin
        nxt_col = '0;
        nxt_row = cur_row + row_t'(1);
      end else begin
        nxt_col = cur_col + col_t'(1);
      end
    end
  end

  // done marks that the frame's last pixel has been consumed; anything
  // after it without a fresh sof is an overrun and keeps the saturated tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else if (win_valid) begin
      col_cnt <= nxt_col;
      row_cnt <= nxt_row;
      done    <= last_px;
      overrun <= sof ? 1'b0 : (overrun | done);
    end
  end

  logic [STAGES-1:0]                   vld_pipe;
  tag_t [STAGES-1:0]                   tag_pipe;
  logic [NUM_ELEM-1:0][PIXEL_DEPTH-1:0] xor_q;
  logic [NUM_ELEM-1:0][POP_W-1:0]       pop;
  logic [COST_W-1:0]                   sum;

  // S1: element-wise XOR plus tag capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q    <= '0;
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      xor_q       <= win_l ^ win_r;
      vld_pipe[0] <= win_valid;
      tag_pipe[0] <= '{row: cur_row, col: cur_col};
      vld_pipe[1] <= vld_pipe[0];
      tag_pipe[1] <= tag_pipe[0];
    end
  end

  // S2: one registered popcount per window element
  for (genvar e = 0; e < NUM_ELEM; e++) begin : g_pop
    popcount32 u_pop (
      .clk (clk),
      .rst (rst),
      .din (xor_q[e]),
      .cnt (pop[e])
    );
  end

  always_comb begin
    sum = '0;
    for (int e = 0; e < NUM_ELEM; e++) sum = sum + COST_W'(pop[e]);
  end

  // S3: outputs only update once the window spans real image rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cost       <= '0;
      cost_valid <= 1'b0;
      cost_col   <= '0;
      cost_row   <= '0;
    end else begin
      cost_valid <= vld_pipe[1] && (tag_pipe[1].row >= row_t'(BLOCK_HEIGHT - 1));
      if (vld_pipe[1] && (tag_pipe[1].row >= row_t'(BLOCK_HEIGHT - 1))) begin
        cost     <= sum;
        cost_col <= tag_pipe[1].col;
        cost_row <= tag_pipe[1].row;
      end
    end
  end

endmodule

// File: tb/tb_window_hamming_cost.sv
// Directed bench for window_hamming_cost; frame height shortened so a full frame fits the run.
module tb_window_hamming_cost;

  localparam int FW = 640;
  localparam int FH = 12;
  localparam int BH = 8;
  localparam int WW = BH * 32;

  logic          clk = 1'b0;
  logic          rst, win_valid, sof;
  logic [WW-1:0] win_l, win_r;
  logic [8:0]    cost;
  logic          cost_valid;
  logic [9:0]    cost_col;
  logic [8:0]    cost_row;
  logic          overrun;

  window_hamming_cost #(
    .BLOCK_WIDTH (1),
    .BLOCK_HEIGHT(BH),
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .win_valid (win_valid),
    .sof       (sof),
    .win_l     (win_l),
    .win_r     (win_r),
    .cost      (cost),
    .cost_valid(cost_valid),
    .cost_col  (cost_col),
    .cost_row  (cost_row),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {int t; int c; int row; int col;} ent_t;
  ent_t gotq[$];
  ent_t expq[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (cost_valid) gotq.push_back(ent_t'{cyc, int'(cost), int'(cost_row), int'(cost_col)});

  function automatic logic [WW-1:0] rnd();
    logic [WW-1:0] v;
    for (int i = 0; i < BH; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Presents one pixel; outputs are expected 3 cycles after presentation.
  task automatic px(input logic s, input logic [WW-1:0] l, input logic [WW-1:0] r,
                    input int row, input int col);
    @(negedge clk);
    win_valid = 1'b1; sof = s; win_l = l; win_r = r;
    if (row >= BH - 1) expq.push_back(ent_t'{cyc + 3, $countones(l ^ r), row, col});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      win_valid = 1'b0; sof = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; win_valid = 1'b0; sof = 1'b0; win_l = '0; win_r = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cost_valid, cost, cost_col, cost_row, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_state got v=%0b cost=%0d col=%0d row=%0d ovr=%0b exp all zero",
               cost_valid, cost, cost_col, cost_row, overrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency_flush();
    logic [WW-1:0] w;
    gotq.delete(); expq.delete();
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < FW; c++)
        if (!(r == BH - 1 && c > 3)) begin
          w = rnd();
          px(r == 0 && c == 0, w, w, r, c);
        end
    @(negedge clk);
    win_valid = 1'b0; sof = 1'b0;
    #2 rst = 1'b1;
    expq = expq[0:1];
    #1;
    checks++;
    if ({cost_valid, cost, cost_col, cost_row, overrun} !== '0) begin
      failures++;
      $display("FAIL midstream_reset got v=%0b cost=%0d col=%0d row=%0d ovr=%0b exp all zero",
               cost_valid, cost, cost_col, cost_row, overrun);
    end
    checks++;
    if (gotq.size() != expq.size()) begin
      failures++;
      $display("FAIL latency_count got %0d exp %0d", gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        failures++;
        $display("FAIL latency[%0d] got t=%0d cost=%0d (%0d,%0d) exp t=%0d cost=%0d (%0d,%0d)", i,
                 gotq[i].t, gotq[i].c, gotq[i].row, gotq[i].col,
                 expq[i].t, expq[i].c, expq[i].row, expq[i].col);
      end
    end
    checks++;
    if (gotq.size() == 0 || gotq[0].row != 7 || gotq[0].col != 0 || gotq[0].c != 0) begin
      failures++;
      $display("FAIL first_valid got n=%0d exp first tag (7,0) cost 0", gotq.size());
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(6);
    checks++;
    if (gotq.size() != 2) begin
      failures++;
      $display("FAIL flush got %0d outputs exp 2", gotq.size());
    end
  endtask

  task automatic test_full_mismatch();
    logic [WW-1:0] w;
    gotq.delete(); expq.delete();
    for (int r = 0; r < BH - 1; r++)
      for (int c = 0; c < FW; c++) begin
        w = rnd();
        px(r == 0 && c == 0, w, w, r, c);
      end
    px(1'b0, '0, '1, 7, 0);
    idle(4);
    checks++;
    if (gotq.size() != 1 || gotq[0].c != 256 || gotq[0].row != 7 || gotq[0].col != 0 ||
        gotq[0] !== expq[0]) begin
      failures++;
      $display("FAIL full_mismatch got n=%0d cost=%0d exp n=1 cost=256 tag (7,0)",
               gotq.size(), gotq.size() ? gotq[0].c : -1);
    end
  endtask

  task automatic test_mixed();
    logic [31:0]   xe [8];
    logic [WW-1:0] l, x;
    xe = '{32'h1, 32'h3, 32'hF, 32'hFF, 32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_0000};
    for (int e = 0; e < BH; e++) x[e*32 +: 32] = xe[e];
    l = rnd();
    gotq.delete(); expq.delete();
    px(1'b0, l, l ^ x, 7, 1);
    idle(4);
    checks++;
    if (gotq.size() != 1 || gotq[0].c != 32 || gotq[0].row != 7 || gotq[0].col != 1 ||
        gotq[0] !== expq[0]) begin
      failures++;
      $display("FAIL mixed got n=%0d cost=%0d exp n=1 cost=32 tag (7,1)",
               gotq.size(), gotq.size() ? gotq[0].c : -1);
    end
  endtask

  task automatic test_gapped();
    int r, c;
    r = 7; c = 2;
    gotq.delete(); expq.delete();
    for (int n = 0; n < FW; n++) begin
      px(1'b0, rnd(), rnd(), r, c);
      if (c == FW - 1) begin c = 0; r++; end
      else c++;
      idle($urandom_range(0, 2));
    end
    idle(4);
    checks++;
    if (gotq.size() != expq.size()) begin
      failures++;
      $display("FAIL gapped_count got %0d exp %0d", gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        failures++;
        $display("FAIL gapped[%0d] got t=%0d cost=%0d (%0d,%0d) exp t=%0d cost=%0d (%0d,%0d)", i,
                 gotq[i].t, gotq[i].c, gotq[i].row, gotq[i].col,
                 expq[i].t, expq[i].c, expq[i].row, expq[i].col);
      end
    end
  endtask

  task automatic test_frame_end();
    logic [WW-1:0] w;
    gotq.delete(); expq.delete();
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++) px(r == 0 && c == 0, rnd(), rnd(), r, c);
    px(1'b0, rnd(), rnd(), FH - 1, FW - 1);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_at_last got %0b exp 0", overrun);
    end
    px(1'b0, rnd(), rnd(), FH - 1, FW - 1);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got %0b exp 1", overrun);
    end
    idle(4);
    checks++;
    if (gotq.size() != expq.size()) begin
      failures++;
      $display("FAIL frame_end_count got %0d exp %0d", gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        failures++;
        $display("FAIL frame_end[%0d] got t=%0d cost=%0d (%0d,%0d) exp t=%0d cost=%0d (%0d,%0d)", i,
                 gotq[i].t, gotq[i].c, gotq[i].row, gotq[i].col,
                 expq[i].t, expq[i].c, expq[i].row, expq[i].col);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got %0b exp 1", overrun);
    end
    w = rnd();
    px(1'b1, w, w, 0, 0);
    idle(1);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got %0b exp 0", overrun);
    end
  endtask

  // Continues the frame restarted at (0,0) by the previous test.
  task automatic test_mid_sof();
    logic [WW-1:0] w;
    gotq.delete(); expq.delete();
    for (int r = 0; r <= 9; r++)
      for (int c = 0; c < FW; c++)
        if (!(r == 0 && c == 0) && (r < 9 || c < 37)) px(1'b0, rnd(), rnd(), r, c);
    w = rnd();
    px(1'b1, w, ~w, 0, 0);
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < FW; c++)
        if (!(r == 0 && c == 0) && (r < BH - 1 || c == 0)) px(1'b0, rnd(), rnd(), r, c);
    idle(4);
    checks++;
    if (gotq.size() != expq.size()) begin
      failures++;
      $display("FAIL mid_sof_count got %0d exp %0d", gotq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      checks++;
      if (gotq[i] !== expq[i]) begin
        failures++;
        $display("FAIL mid_sof[%0d] got t=%0d cost=%0d (%0d,%0d) exp t=%0d cost=%0d (%0d,%0d)", i,
                 gotq[i].t, gotq[i].c, gotq[i].row, gotq[i].col,
                 expq[i].t, expq[i].c, expq[i].row, expq[i].col);
      end
    end
    checks++;
    if (gotq.size() < 2 || gotq[gotq.size()-2].row != 9 || gotq[gotq.size()-2].col != 36 ||
        gotq[gotq.size()-1].row != 7 || gotq[gotq.size()-1].col != 0) begin
      failures++;
      $display("FAIL mid_sof_tags got n=%0d exp last tags (9,36) then (7,0)", gotq.size());
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL mid_sof_overrun got %0b exp 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_latency_flush();
    test_full_mismatch();
    test_mixed();
    test_gapped();
    test_frame_end();
    test_mid_sof();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_hamming_cost.md
Name: window_hamming_cost

Overview:
Downstream consumer of the scan-line window buffers in the SGM datapath. Takes two column windows of 32-bit census codes, one from the left-image line buffer and one from the right-image line buffer. Computes the Hamming matching cost as the sum of popcount(L xor R) over every window element, in a fixed 3-cycle pipeline. Tracks raster position so a cost is flagged valid only once the windows hold a full column of real image rows; the cost feeds the SGM path-aggregation stage.

Parameters:
BLOCK_WIDTH, 1, window columns (must match upstream line buffers)
BLOCK_HEIGHT, 8, window rows (must match upstream line buffers)
FRAME_WIDTH, 640, pixels per line
FRAME_HEIGHT, 480, lines per frame
PIXEL_DEPTH, 32, census code width; fixed, not overridable
COST_W, clog2(BLOCK_WIDTH*BLOCK_HEIGHT*PIXEL_DEPTH+1), cost width (9 at defaults)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
win_valid  in  1  both windows hold a newly shifted pixel this cycle (upstream enable delayed 1 clk)
sof  in  1  qualified by win_valid; this pixel is row 0, col 0 of a new frame
win_l  in  BLOCK_WIDTH*BLOCK_HEIGHT*PIXEL_DEPTH  left window, same packing as line buffer output
win_r  in  BLOCK_WIDTH*BLOCK_HEIGHT*PIXEL_DEPTH  right window, same packing
cost  out  COST_W  Hamming cost
cost_valid  out  1  cost, cost_col and cost_row are valid this cycle
cost_col  out  10  column tag of the pixel that produced cost
cost_row  out  9  row tag of the pixel that produced cost
overrun  out  1  sticky; pixels arrived past the last pixel of a frame

Behaviour:
- Reset (async, rst=1): all pipeline registers 0; cost=0, cost_valid=0, cost_col=0, cost_row=0, overrun=0; col/row counters 0.
- Position counters advance only on win_valid.
  - Current pixel position = (row, col). After each win_valid pixel, col increments.
  - At col=FRAME_WIDTH-1, col wraps to 0 and row increments.
- sof with win_valid: current pixel is treated as (0,0) regardless of counter state; next pixel is (0,1). Counters also resynchronise mid-frame.
- Last pixel of frame, (FRAME_HEIGHT-1, FRAME_WIDTH-1): next position holds at (FRAME_HEIGHT-1, FRAME_WIDTH-1).
  - Any further win_valid without sof sets overrun; tags stay saturated.
  - overrun clears only on rst or on the next sof.
- Pipeline, free-running with no stall; valid bit travels alongside the data:
  - S1: register XOR of all BLOCK_WIDTH*BLOCK_HEIGHT element pairs, valid, col, row.
  - S2: per-element popcount, each 6 bits (range 0..32), registered.
  - S3: adder-tree sum zero-extended to COST_W; no saturation is needed because the width is exact. Registered to outputs.
- Latency: exactly 3 clk from win_valid sampled high to cost_valid high. Back-to-back win_valid gives back-to-back cost_valid.
- Window fill: cost_valid = S3 valid AND tagged row >= BLOCK_HEIGHT-1. Rows 0..BLOCK_HEIGHT-2 produce no valid output but still pass through the pipeline.
- When cost_valid=0, cost/cost_col/cost_row hold their last values. Verification must not check them in that state.
- Simultaneous sof and in-flight pixels: in-flight pixels keep their old tags and drain normally.
- rst mid-frame: pipeline is flushed immediately and nothing pending is emitted. Next output comes only after a new sof and BLOCK_HEIGHT-1 rows.

Decomposition:
- Shared SGM package:
  - PIXEL_DEPTH=32, FRAME_WIDTH, FRAME_HEIGHT.
  - Census code typedef (32-bit).
  - Cost typedef sized by COST_W.
  - Column/row tag typedefs (10/9 bits).
- Sub-module popcount32: registered 32-bit popcount with 6-bit result, instantiated BLOCK_WIDTH*BLOCK_HEIGHT times in S2. Reused later by the aggregation stage.

Test Plan:
- Reset and latency: rst mid-stream, then sof, 8 full rows with win_l=win_r → cost_valid=0 for rows 0..6; first valid at row 7 col 0, exactly 3 clk after its win_valid; cost=0; overrun=0.
- Full mismatch: row>=7, win_l all 0x00000000, win_r all 0xFFFFFFFF → cost=256.
- Mixed elements: elements 0..7 XOR = 0x1, 0x3, 0xF, 0xFF, 0, 0, 0x80000000, 0xFFFF0000 → cost=1+2+4+8+0+0+1+16=32. Tags must match the input position.
- Gapped stream: win_valid toggling 1-0-1 with random idle gaps → each cost exactly 3 clk after its pixel; tags contiguous; col wraps 639→0 with row+1.
- Frame end and overrun: drive 640×480 pixels plus 2 extra with no sof → last valid tag (479,639); overrun=1 after the first extra pixel; the next sof clears overrun and restarts at (0,0).
- Mid-frame sof: sof at row 100 col 37 → that pixel is tagged (0,0); no cost_valid until row 7 of the new frame; pixels already in flight emit with their old tags.
